// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline stage register with a valid/ready handshake
// and a 2-entry skid buffer (main entry drives out_data, skid entry catches the
// payload accepted while downstream stalls). in_ready is registered, so the
// upstream ready path never sees combinational logic from out_ready.
// Optional build macro: PIPE_STATS_EN adds the stall_cnt/kill_cnt statistics
// ports and their saturating counters.
module pipe_stage_skid #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0
`ifdef PIPE_STATS_EN
  , parameter int              CNT_W     = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] kill_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  // Occupancy transition; a flush always empties the stage.
  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (in_fire) state_next = BUSY;
      BUSY: begin
        if (in_fire && !out_fire)      state_next = FULL;
        else if (!in_fire && out_fire) state_next = EMPTY;
      end
      FULL:    if (out_fire) state_next = BUSY;
      default: state_next = EMPTY;
    endcase
    if (flush) state_next = EMPTY;
  end

  // State, payload storage and the registered in_ready (low only when FULL next).
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state    <= EMPTY;
      main_q   <= FLUSH_VAL;
      skid_q   <= FLUSH_VAL;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
      unique case (state)
        EMPTY: if (in_fire) main_q <= in_data;
        BUSY: begin
          if (in_fire && out_fire) main_q <= in_data;
          else if (in_fire)        skid_q <= in_data;
        end
        FULL:    if (out_fire) main_q <= skid_q;
        default: ;
      endcase
    end
  end

`ifdef PIPE_STATS_EN
  logic [1:0]     held_cnt;
  logic [1:0]     killed;
  logic [CNT_W:0] kill_sum;

  assign held_cnt = (state == FULL) ? 2'd2 : (state == BUSY) ? 2'd1 : 2'd0;
  assign killed   = held_cnt - {1'b0, out_fire};
  assign kill_sum = {1'b0, kill_cnt} + {{(CNT_W-1){1'b0}}, killed};

  // Saturating count of cycles the head payload waits on downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Saturating count of valid entries thrown away by flush (a head consumed that cycle survives).
  always_ff @(posedge clock) begin
    if (reset) begin
      kill_cnt <= '0;
    end else if (flush) begin
      kill_cnt <= kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scenario tasks for pipe_stage_skid plus a scoreboard
// monitor that records every accepted payload and matches it against what
// leaves the stage, and checks payloads stay stable while stalled.
module tb_pipe_stage_skid;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] FLUSH_VAL = '0;
`ifdef PIPE_STATS_EN
  localparam int CNT_W = 4;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  kill_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb[$];
  logic              hold_pending = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .FLUSH_VAL(FLUSH_VAL)
`ifdef PIPE_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt)
    , .kill_cnt(kill_cnt)
`endif
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_data) begin
          errors++;
          $display("[TB] FAIL hold_stable: got valid=%b data=%h, need valid=1 data=%h", out_valid, out_data, hold_data);
        end
      end
      hold_pending = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected: got data=%h, need no output", out_data);
        end else begin
          logic [DATA_W-1:0] exp;
          exp = sb.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("[TB] FAIL sb_order: got %h, need %h", out_data, exp);
          end
        end
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (in_valid && in_ready) sb.push_back(in_data);
        if (out_valid && !out_ready) begin
          hold_pending = 1'b1;
          hold_data    = out_data;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;
    step();
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    out_ready = 1'b0;
    reset     = 1'b1;
    step(2);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, need 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b, need 1", in_ready); end
    checks++;
    if (out_data !== FLUSH_VAL) begin errors++; $display("[TB] FAIL reset_data: got %h, need %h", out_data, FLUSH_VAL); end
`ifdef PIPE_STATS_EN
    checks++;
    if (stall_cnt !== '0 || kill_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d/%0d, need 0/0", stall_cnt, kill_cnt); end
`endif
    in_valid = 1'b0;
    reset    = 1'b0;
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i)) begin
        errors++;
        $display("[TB] FAIL stream_data: got valid=%b data=%h, need valid=1 data=%h", out_valid, out_data, DATA_W'(i));
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready: got %b, need 1", in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got %b, need 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    step();
    in_data   = 16'h000B;
    step();
    in_data   = 16'h000C;
    step(3);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h000A) begin
      errors++;
      $display("[TB] FAIL stall_head: got valid=%b data=%h, need valid=1 data=000a", out_valid, out_data);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready: got %b, need 0", in_ready); end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== 16'h000B || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release_b: got data=%h ready=%b, need data=000b ready=1", out_data, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 16'h000C || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release_c: got valid=%b data=%h, need valid=1 data=000c", out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain: got %b, need 0", out_valid); end
  endtask

  task automatic test_flush_full();
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'h000A;
    step();
    in_data  = 16'h000B;
    step();
    in_data  = 16'h000C;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== FLUSH_VAL || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_full: got valid=%b data=%h ready=%b, need valid=0 data=%h ready=1", out_valid, out_data, in_ready, FLUSH_VAL);
    end
`ifdef PIPE_STATS_EN
    checks++;
    if (kill_cnt !== 4'd2) begin errors++; $display("[TB] FAIL flush_full_kill: got %0d, need 2", kill_cnt); end
`endif
    out_ready = 1'b1;
    step(3);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_full_ghost: got %b, need 0", out_valid); end
  endtask

  task automatic test_flush_fire();
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'h000A;
    step();
    in_data  = 16'h000B;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== FLUSH_VAL) begin
      errors++;
      $display("[TB] FAIL flush_fire: got valid=%b data=%h, need valid=0 data=%h", out_valid, out_data, FLUSH_VAL);
    end
`ifdef PIPE_STATS_EN
    checks++;
    if (kill_cnt !== 4'd1) begin errors++; $display("[TB] FAIL flush_fire_kill: got %0d, need 1", kill_cnt); end
`endif
    step(3);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_fire_ghost: got %b, need 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(4);
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL b2b_loss: got %0d pending, need 0", sb.size()); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b, need 0", out_valid); end
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'h00EE;
    step();
    in_valid = 1'b0;
    step(20);
    checks++;
    if (stall_cnt !== 4'hF) begin errors++; $display("[TB] FAIL stall_sat: got %0d, need 15", stall_cnt); end
    step(3);
    checks++;
    if (stall_cnt !== 4'hF) begin errors++; $display("[TB] FAIL stall_sat_hold: got %0d, need 15", stall_cnt); end
    do_reset();
    checks++;
    if (stall_cnt !== '0) begin errors++; $display("[TB] FAIL stall_clear: got %0d, need 0", stall_cnt); end
  endtask
`endif

  // Scenario sequence.
  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush_full();
    test_flush_fire();
    test_back_to_back();
`ifdef PIPE_STATS_EN
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
